wb_byte_fifo_slave: RTL

WB_BYTE_FIFO_SLAVE -- requirements
Module: wb_byte_fifo_slave

---
 rtl/wb_byte_fifo_slave_if.sv | 27 ++
 rtl/wb_byte_fifo_slave.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/wb_byte_fifo_slave_if.sv
// Wishbone classic slave bundle for the byte FIFO register block.
interface wb_byte_fifo_slave_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic [AW-1:0] wbs_adr_i;
  logic [DW-1:0] wbs_dat_i;
  logic [3:0]    wbs_sel_i;
  logic          wbs_we_i;
  logic          wbs_stb_i;
  logic          wbs_cyc_i;
  logic [DW-1:0] wbs_dat_o;
  logic          wbs_ack_o;
  logic          wbs_rty_o;
  logic          wbs_err_o;
  logic          wbs_inta_o;

  modport master (
    output wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_stb_i, wbs_cyc_i,
    input  wbs_dat_o, wbs_ack_o, wbs_rty_o, wbs_err_o, wbs_inta_o
  );

  modport slave (
    input  wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_we_i, wbs_stb_i, wbs_cyc_i,
    output wbs_dat_o, wbs_ack_o, wbs_rty_o, wbs_err_o, wbs_inta_o
  );
endinterface

// File: rtl/wb_byte_fifo_slave.sv
// Wishbone slave exposing a byte FIFO through DATA/STATUS/COUNT/CTRL registers.
// Every request is answered exactly one cycle later with ack, rty or err.
module wb_byte_fifo_slave #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                 hclk,
  input  logic                 hresetn,
  wb_byte_fifo_slave_if.slave  wbs
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  localparam logic [AW-1:0]         ADR_DATA   = AW'(2'd0);
  localparam logic [AW-1:0]         ADR_STATUS = AW'(2'd1);
  localparam logic [AW-1:0]         ADR_COUNT  = AW'(2'd2);
  localparam logic [AW-1:0]         ADR_CTRL   = AW'(2'd3);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1'b1);
  localparam logic [CW-1:0]         CNT_ONE    = CW'(1'b1);
  localparam logic [CW-1:0]         CNT_FULL   = CW'(DEPTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic                  ack_q, ack_d;
  logic                  rty_q, rty_d;
  logic                  err_q, err_d;
  logic                  inta_q, inta_d;
  logic [DW-1:0]         dat_q, dat_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  irq_en_q, irq_en_d;
  logic [3:0]            thr_q, thr_d;
  logic [7:0]            mem_q [DEPTH];

  logic       req_s;
  logic       hit_data_s, hit_status_s, hit_count_s, hit_ctrl_s, mapped_s;
  logic       err_s, rty_s;
  logic       empty_s, full_s, irq_cond_s;
  logic       push_s;
  logic [7:0] status_s, ctrl_s;
  logic       unused_s;

  // Only byte lane 0 carries a register; the other selects are don't-care.
  assign unused_s = ^wbs.wbs_sel_i[3:1];

  assign req_s        = wbs.wbs_cyc_i & wbs.wbs_stb_i;
  assign hit_data_s   = (wbs.wbs_adr_i == ADR_DATA);
  assign hit_status_s = (wbs.wbs_adr_i == ADR_STATUS);
  assign hit_count_s  = (wbs.wbs_adr_i == ADR_COUNT);
  assign hit_ctrl_s   = (wbs.wbs_adr_i == ADR_CTRL);
  assign mapped_s     = hit_data_s | hit_status_s | hit_count_s | hit_ctrl_s;

  assign empty_s    = (count_q == {CW{1'b0}});
  assign full_s     = (count_q == CNT_FULL);
  assign irq_cond_s = !empty_s && (32'(count_q) >= 32'(thr_q));

  // Error outranks retry so a malformed access never touches the FIFO.
  assign err_s = !mapped_s | !wbs.wbs_sel_i[0] |
                 (wbs.wbs_we_i & (hit_status_s | hit_count_s));
  assign rty_s = hit_data_s & ((wbs.wbs_we_i & full_s) | (!wbs.wbs_we_i & empty_s));

  assign status_s = {5'b00000, irq_cond_s, full_s, empty_s};
  assign ctrl_s   = {thr_q, 2'b00, 1'b0, irq_en_q};

  // Request decode, termination choice and register/FIFO side effects.
  always_comb begin
    state_d  = state_q;
    ack_d    = 1'b0;
    rty_d    = 1'b0;
    err_d    = 1'b0;
    dat_d    = dat_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    irq_en_d = irq_en_q;
    thr_d    = thr_q;
    push_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          state_d = RESP;
          if (err_s) begin
            err_d = 1'b1;
          end else if (rty_s) begin
            rty_d = 1'b1;
          end else begin
            ack_d = 1'b1;
            if (wbs.wbs_we_i) begin
              if (hit_data_s) begin
                push_s   = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                count_d  = count_q + CNT_ONE;
              end else begin
                // Only CTRL is writable once errors are filtered out.
                irq_en_d = wbs.wbs_dat_i[0];
                thr_d    = wbs.wbs_dat_i[7:4];
                if (wbs.wbs_dat_i[1]) begin
                  wr_ptr_d = {DEPTH_LOG2{1'b0}};
                  rd_ptr_d = {DEPTH_LOG2{1'b0}};
                  count_d  = {CW{1'b0}};
                end else begin
                  count_d = count_q;
                end
              end
            end else begin
              if (hit_data_s) begin
                dat_d    = DW'(mem_q[rd_ptr_q]);
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                count_d  = count_q - CNT_ONE;
              end else if (hit_status_s) begin
                dat_d = DW'(status_s);
              end else if (hit_count_s) begin
                dat_d = DW'(count_q);
              end else begin
                dat_d = DW'(ctrl_s);
              end
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    inta_d = irq_en_q & irq_cond_s;
  end

  // Control, pointer and response registers with asynchronous reset.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      rty_q    <= 1'b0;
      err_q    <= 1'b0;
      inta_q   <= 1'b0;
      dat_q    <= {DW{1'b0}};
      wr_ptr_q <= {DEPTH_LOG2{1'b0}};
      rd_ptr_q <= {DEPTH_LOG2{1'b0}};
      count_q  <= {CW{1'b0}};
      irq_en_q <= 1'b0;
      thr_q    <= 4'h0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      rty_q    <= rty_d;
      err_q    <= err_d;
      inta_q   <= inta_d;
      dat_q    <= dat_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      irq_en_q <= irq_en_d;
      thr_q    <= thr_d;
    end
  end

  // FIFO storage; contents survive flush and reset, only the pointers move.
  always_ff @(posedge hclk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wbs.wbs_dat_i[7:0];
    end
  end

  assign wbs.wbs_ack_o  = ack_q;
  assign wbs.wbs_rty_o  = rty_q;
  assign wbs.wbs_err_o  = err_q;
  assign wbs.wbs_dat_o  = dat_q;
  assign wbs.wbs_inta_o = inta_q;

endmodule
